result_trace_buffer: RTL and testbench

RESULT_TRACE_BUFFER -- requirements
Module: result_trace_buffer

---
 rtl/result_trace_buffer.sv | 118 +++++++++++
 tb/tb_result_trace_buffer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/result_trace_buffer.sv
// result_trace_buffer
//   Trace FIFO for the single-cycle computer. On capture_en it stores the
//   {addr, Result} pair, and a consumer drains entries with a valid/ready
//   handshake. When a sample arrives while the FIFO is full and nothing is
//   popped that cycle, the sample is dropped and the sticky overflow flag is set.
//
//   Optional build macro: RESULT_TRACE_DEDUP_EN
//     When defined, a capture whose addr equals the last accepted addr is
//     skipped. A skipped capture is neither a push nor an overflow.
//
// Parameters
//   DEPTH : number of FIFO entries (power of two, 2..256)
//   CW    : count width, log2(DEPTH)+1
//
// Ports
//   Clock        in   single clock; all state updates on its rising edge
//   Reset        in   synchronous, active-high reset
//   Result       in   32-bit result word
//   addr         in   32-bit PC/address paired with Result
//   capture_en   in   sample {addr, Result} at this edge
//   clr_overflow in   clear the sticky overflow flag
//   out_ready    in   consumer accepts the head entry
//   out_valid    out  head entry present (not empty)
//   out_addr     out  addr field of the head entry, 0 when empty
//   out_data     out  Result field of the head entry, 0 when empty
//   count        out  number of stored entries, 0..DEPTH
//   full, empty  out  count==DEPTH, count==0
//   overflow     out  sticky: a sample was dropped

module result_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [31:0]   Result,
    input  logic [31:0]   addr,
    input  logic          capture_en,
    input  logic          clr_overflow,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [31:0]   out_addr,
    output logic [31:0]   out_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    localparam int AW = CW - 1;

    logic [31:0]   mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    // The pointers carry one extra wrap bit. That bit lets the pointer
    // difference tell full (DEPTH) apart from empty (0).
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic          push_cand;
    logic          push;
    logic          pop;
    logic          drop;

    assign count     = wr_ptr - rd_ptr;
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign out_valid = ~empty;

    assign pop  = out_valid & out_ready;
    // Popping in the same cycle frees a slot, so a push is accepted even when full.
    assign push = push_cand & (~full | pop);
    assign drop = push_cand & full & ~pop;

    assign out_addr = empty ? '0 : mem_addr[rd_ptr[AW-1:0]];
    assign out_data = empty ? '0 : mem_data[rd_ptr[AW-1:0]];

`ifdef RESULT_TRACE_DEDUP_EN
    logic [31:0] last_addr;
    logic        last_valid;

    assign push_cand = capture_en & ~(last_valid & (addr == last_addr));

    // Only accepted pushes are remembered. A dropped sample never becomes the
    // dedup reference.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            last_valid <= 1'b0;
            last_addr  <= '0;
        end else if (push) begin
            last_valid <= 1'b1;
            last_addr  <= addr;
        end
    end
`else
    assign push_cand = capture_en;
`endif

    always_ff @(posedge Clock) begin
        if (!Reset && push) begin
            mem_addr[wr_ptr[AW-1:0]] <= addr;
            mem_data[wr_ptr[AW-1:0]] <= Result;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            // A drop in the same cycle wins over a clear request.
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_result_trace_buffer.sv
module tb_result_trace_buffer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] Result;
    logic [31:0] addr;
    logic        capture_en;
    logic        clr_overflow;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];

    result_trace_buffer #(.DEPTH(16), .CW(5)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Result       (Result),
        .addr         (addr),
        .capture_en   (capture_en),
        .clr_overflow (clr_overflow),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Result = '0; addr = '0;
        capture_en = 1'b0; clr_overflow = 1'b0; out_ready = 1'b0;
        repeat (5) tick();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", out_valid, 0);
        check("rst_addr", out_addr, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", overflow, 0);
        Reset = 1'b0;

        // Three captures, consumer stalled
        capture_en = 1'b1; addr = 32'h0; Result = 32'h11;
        tick();
        check("lat_valid", out_valid, 1);
        check("lat_addr", out_addr, 32'h0);
        check("lat_data", out_data, 32'h11);
        addr = 32'h4; Result = 32'h22; tick();
        addr = 32'h8; Result = 32'h33; tick();
        capture_en = 1'b0;
        check("cnt3", count, 3);
        tick();
        check("hold_data", out_data, 32'h11);

        // Drain
        out_ready = 1'b1;
        check("drain0", out_data, 32'h11); tick();
        check("drain1", out_data, 32'h22); tick();
        check("drain2", out_data, 32'h33); tick();
        check("drain_empty", empty, 1);
        check("drain_data0", out_data, 0);
        out_ready = 1'b0;

        // Fill with 17 captures: the last one is dropped
        capture_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            addr = 32'h100 + 32'(i * 4); Result = 32'hA000 + 32'(i);
            if (i < 16) begin q_addr.push_back(addr); q_data.push_back(Result); end
            tick();
        end
        capture_en = 1'b0;
        check("fill_count", count, 16);
        check("fill_full", full, 1);
        check("fill_ovf", overflow, 1);
        check("fill_head_addr", out_addr, 32'h100);
        check("fill_head_data", out_data, 32'hA000);

        // A drop and a clear in the same cycle: the drop wins
        capture_en = 1'b1; clr_overflow = 1'b1; addr = 32'h1F0; Result = 32'hDEAD;
        tick();
        check("set_wins_ovf", overflow, 1);
        check("set_wins_head", out_data, 32'hA000);
        capture_en = 1'b0;
        tick();
        check("clr_ovf", overflow, 0);
        clr_overflow = 1'b0;

        // Full: push and pop every cycle across the pointer wrap
        capture_en = 1'b1; out_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            addr = 32'h200 + 32'(j * 4); Result = 32'hB000 + 32'(j);
            check("wrap_data", out_data, q_data[0]);
            check("wrap_addr", out_addr, q_addr[0]);
            void'(q_addr.pop_front()); void'(q_data.pop_front());
            q_addr.push_back(addr); q_data.push_back(Result);
            tick();
        end
        capture_en = 1'b0; out_ready = 1'b0;
        check("wrap_count", count, 16);
        check("wrap_ovf", overflow, 0);
        check("wrap_head", out_data, q_data[0]);

        // Pop 9 entries to leave 7
        out_ready = 1'b1;
        repeat (9) tick();
        out_ready = 1'b0;
        check("cnt7", count, 7);
        check("cnt7_head", out_data, 32'hB000 + 32'd13);

        // Reset has priority over the capture and the pop
        Reset = 1'b1; capture_en = 1'b1; out_ready = 1'b1; addr = 32'h2FC;
        tick();
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ovf", overflow, 0);
        Reset = 1'b0; out_ready = 1'b0; addr = 32'h300; Result = 32'hC0;
        tick();
        capture_en = 1'b0;
        check("post_rst_count", count, 1);
        check("post_rst_addr", out_addr, 32'h300);

        // Repeated address stimulus
        Reset = 1'b1; tick(); Reset = 1'b0;
        capture_en = 1'b1; addr = 32'h40;
        for (int k = 0; k < 4; k++) begin
            Result = 32'h50 + 32'(k);
            tick();
        end
        addr = 32'h44; Result = 32'h60; tick();
        capture_en = 1'b0;
`ifdef RESULT_TRACE_DEDUP_EN
        check("dedup_count", count, 2);
`else
        check("dedup_count", count, 5);
`endif
        check("dedup_head", out_data, 32'h50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
